// File: rtl/mat4x4_pkg.sv
// Shared definitions for the 4x4 matrix transform controller: FSM states,
// matrix geometry and a row-offset helper for 4W-bit rows.
package mat4x4_pkg;

    localparam int ROWS = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Bit offset of row 'row' inside a packed matrix whose elements are w bits wide.
    function automatic int row_lsb(input int row, input int w);
        return row * ROWS * w;
    endfunction

endpackage

// File: rtl/data_4x4_transform.sv
// Transpose datapath: output element (r,c) = input element (c,r), delivered
// through a LAT-deep register pipeline.
module data_4x4_transform
    import mat4x4_pkg::*;
#(
    parameter int W   = 8,
    parameter int LAT = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [ROWS*ROWS*W-1:0]   data,
    output logic [ROWS*ROWS*W-1:0]   data_out
);

    localparam int MW = ROWS * ROWS * W;

    logic [MW-1:0] xposed;
    logic [MW-1:0] pipe [LAT];

    always_comb begin
        xposed = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < ROWS; c++) begin
                xposed[(r*ROWS + c)*W +: W] = data[(c*ROWS + r)*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= xposed;
            for (int i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign data_out = pipe[LAT-1];

endmodule

// File: rtl/mat4x4_transform_ctrl.sv
// Collects four rows into a 4x4 matrix, runs the transform for its fixed
// latency, then drains the result row by row under valid/ready flow control.
module mat4x4_transform_ctrl
    import mat4x4_pkg::*;
#(
    parameter int W      = 8,
    parameter int XF_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*W-1:0]    in_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*W-1:0]    out_row,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int RW = ROWS * W;
    localparam int MW = ROWS * RW;

    state_t        state;
    logic [1:0]    row_idx;
    logic [3:0]    lat_cnt;
    logic [MW-1:0] matrix;
    logic [MW-1:0] obuf;
    logic [MW-1:0] xf_out;

    data_4x4_transform #(
        .W   (W),
        .LAT (XF_LAT)
    ) u_xf (
        .clk      (clk),
        .rstn     (rstn),
        .data     (matrix),
        .data_out (xf_out)
    );

    // in_ready is only high in FILL, so in_valid alone qualifies an accept there.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= FILL;
            row_idx   <= 2'd0;
            lat_cnt   <= 4'd0;
            matrix    <= '0;
            obuf      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_row   <= '0;
            busy      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        matrix[row_lsb(int'(row_idx), W) +: RW] <= in_row;
                        busy <= 1'b1;
                        if (row_idx == 2'd3) begin
                            row_idx  <= 2'd0;
                            lat_cnt  <= 4'(XF_LAT);
                            in_ready <= 1'b0;
                            state    <= WAIT;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt == 4'd0) begin
                        obuf      <= xf_out;
                        out_row   <= xf_out[RW-1:0];
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DRAIN;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (row_idx == 2'd3) begin
                            row_idx   <= 2'd0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_row   <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b0;
                            frame_cnt <= frame_cnt + 1'b1;
                            state     <= FILL;
                        end else begin
                            row_idx  <= row_idx + 2'd1;
                            out_row  <= obuf[row_lsb(int'(row_idx) + 1, W) +: RW];
                            out_last <= (row_idx == 2'd2);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_mat4x4_transform_ctrl.sv
// Self-checking bench for mat4x4_transform_ctrl: directed and randomized frames
// compared against a transpose reference model, on two parameterizations.
module tb_mat4x4_transform_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  in_valid = '0;
    logic [1:0]  out_ready = '1;
    logic [1:0]  in_ready, out_valid, out_last, busy;
    logic [31:0] in_row [2] = '{32'h0, 32'h0};
    logic [31:0] out_row0, out_row1;
    logic [15:0] frame_cnt0;
    logic [1:0]  frame_cnt1;

    int          checks = 0;
    int          errors = 0;
    int          fc_model [2] = '{0, 0};
    logic [31:0] exp_rows [4];

    always #5 clk = ~clk;

    mat4x4_transform_ctrl #(.W(8), .XF_LAT(1), .CNT_W(16)) dut0 (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_row(in_row[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_row(out_row0),
        .out_last(out_last[0]), .busy(busy[0]), .frame_cnt(frame_cnt0)
    );

    mat4x4_transform_ctrl #(.W(8), .XF_LAT(3), .CNT_W(2)) dut1 (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_row(in_row[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_row(out_row1),
        .out_last(out_last[1]), .busy(busy[1]), .frame_cnt(frame_cnt1)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] get_row(input int sel);
        return (sel == 0) ? out_row0 : out_row1;
    endfunction

    function automatic logic [15:0] get_fc(input int sel);
        return (sel == 0) ? frame_cnt0 : {14'd0, frame_cnt1};
    endfunction

    task automatic doReset();
        @(negedge clk);
        rstn = 1'b0;
        in_valid = '0;
        out_ready = '1;
        #1;
        for (int s = 0; s < 2; s++) begin
            checkOutput("rst_out_valid", out_valid[s], 1'b0);
            checkOutput("rst_out_last", out_last[s], 1'b0);
            checkOutput("rst_out_row", get_row(s), 32'h0);
            checkOutput("rst_busy", busy[s], 1'b0);
            checkOutput("rst_frame_cnt", get_fc(s), 16'h0);
            fc_model[s] = 0;
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) checkOutput("rel_in_ready", in_ready[s], 1'b1);
    endtask

    task automatic sendRow(input int sel, input logic [31:0] row, input int idx, input bit bubbly);
        if (bubbly) begin
            @(negedge clk);
            in_valid[sel] = 1'b0;
            in_row[sel] = $urandom;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid[sel] = 1'b1;
        in_row[sel] = row;
        checkOutput("fill_in_ready", in_ready[sel], 1'b1);
        checkOutput("fill_busy", busy[sel], (idx != 0));
        @(posedge clk);
    endtask

    // Sends a full frame, computes the expected transposed rows, measures latency.
    task automatic applyStimulus(input int sel, input logic [31:0] rows [4], input bit bubbly, input bit hold);
        int n;
        for (int i = 0; i < 4; i++) sendRow(sel, rows[i], i, bubbly);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                exp_rows[r][8*c +: 8] = rows[c][8*r +: 8];
        @(negedge clk);
        in_valid[sel] = hold;
        in_row[sel] = $urandom;
        checkOutput("wait_in_ready", in_ready[sel], 1'b0);
        checkOutput("wait_busy", busy[sel], 1'b1);
        n = 0;
        while (!out_valid[sel] && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checkOutput("latency", n, (sel == 0) ? 2 : 4);
    endtask

    // mode 0: always ready, 1: five-cycle stall on row 1, 2: random ready.
    task automatic drainFrame(input int sel, input int mode, input int nrows);
        int idx = 0;
        int guard = 0;
        int stalls = 0;
        bit rdy;
        while (idx < nrows && guard < 200) begin
            checkOutput("drain_valid", out_valid[sel], 1'b1);
            checkOutput("drain_row", get_row(sel), exp_rows[idx]);
            checkOutput("drain_last", out_last[sel], (idx == 3));
            checkOutput("drain_in_ready", in_ready[sel], 1'b0);
            if (mode == 0) rdy = 1'b1;
            else if (mode == 1) begin
                rdy = !(idx == 1 && stalls < 5);
                if (!rdy) stalls++;
            end else rdy = 1'($urandom_range(0, 1));
            out_ready[sel] = rdy;
            @(posedge clk);
            if (rdy) idx++;
            guard++;
            @(negedge clk);
        end
        checkOutput("drain_rows", idx, nrows);
        out_ready[sel] = 1'b1;
        in_valid[sel] = 1'b0;
        if (nrows == 4) begin
            fc_model[sel] = (fc_model[sel] + 1) % ((sel == 0) ? 65536 : 4);
            checkOutput("done_out_valid", out_valid[sel], 1'b0);
            checkOutput("done_out_last", out_last[sel], 1'b0);
            checkOutput("done_in_ready", in_ready[sel], 1'b1);
            checkOutput("done_busy", busy[sel], 1'b0);
            checkOutput("done_frame_cnt", get_fc(sel), fc_model[sel]);
        end
    endtask

    initial begin
        logic [31:0] basic [4];
        logic [31:0] nonsym [4];
        logic [31:0] rnd [4];
        int          wrap_seq [5];
        basic  = '{32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404};
        nonsym = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        wrap_seq = '{1, 2, 3, 0, 1};

        $display("[TB] reset");
        doReset();

        $display("[TB] basic transpose");
        applyStimulus(0, basic, 1'b0, 1'b0);
        drainFrame(0, 0, 4);

        $display("[TB] non-symmetric matrix");
        applyStimulus(0, nonsym, 1'b0, 1'b0);
        drainFrame(0, 0, 4);

        $display("[TB] back-pressure");
        applyStimulus(0, nonsym, 1'b0, 1'b0);
        drainFrame(0, 1, 4);

        $display("[TB] bubbly input, valid held through wait/drain");
        applyStimulus(0, basic, 1'b1, 1'b1);
        drainFrame(0, 0, 4);

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 4; i++) rnd[i] = $urandom;
            applyStimulus(0, rnd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drainFrame(0, 2, 4);
        end

        $display("[TB] reset mid-fill");
        sendRow(0, 32'hDEADBEEF, 0, 1'b0);
        sendRow(0, 32'hCAFEF00D, 1, 1'b0);
        doReset();
        applyStimulus(0, nonsym, 1'b0, 1'b0);
        drainFrame(0, 0, 4);

        $display("[TB] reset mid-drain");
        applyStimulus(0, basic, 1'b0, 1'b0);
        drainFrame(0, 0, 2);
        out_ready[0] = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_valid", out_valid[0], 1'b1);
        doReset();
        for (int i = 0; i < 4; i++) rnd[i] = $urandom;
        applyStimulus(0, rnd, 1'b0, 1'b0);
        drainFrame(0, 0, 4);

        $display("[TB] counter wrap and XF_LAT=3");
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 4; i++) rnd[i] = $urandom;
            applyStimulus(1, rnd, 1'b0, 1'b0);
            drainFrame(1, 0, 4);
            checkOutput("fc_wrap", {14'd0, frame_cnt1}, wrap_seq[f]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mat4x4_transform_ctrl.md
# mat4x4_transform_ctrl

- Sequences the `data_4x4_transform` datapath over a row stream.
- Collects four W·4-bit rows from an upstream valid/ready stream into a 4×4 matrix of W-bit elements.
- Launches the transform, waits its fixed latency, then drains the transformed matrix row by row on a downstream valid/ready stream.
- Sits between the row-oriented producer and consumer so neither needs to know the transform's width or latency.

## Interface
Parameters:
- `W`, 8, element width in bits; matrix is 16·W bits.
- `XF_LAT`, 1, cycles from stable transform input to valid registered transform output; legal range 1–15.
- `CNT_W`, 16, width of the completed-frame counter.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream row valid.
- `in_ready`  out  1  block accepts a row this cycle.
- `in_row`  in  4·W  row data; element c at bits [W·c+W-1 : W·c].
- `out_valid`  out  1  downstream row valid.
- `out_ready`  in  1  downstream accepts the row.
- `out_row`  out  4·W  transformed row, same element packing as `in_row`.
- `out_last`  out  1  high with the 4th (final) output row of a frame.
- `busy`  out  1  high in any state other than FILL with row count 0.
- `frame_cnt`  out  CNT_W  count of fully drained frames.

## Operation
- Matrix packing: row r occupies matrix bits [4W·r+4W-1 : 4W·r]. The first accepted row is r=0, i.e. the least-significant row.
- `data_4x4_transform` computes a transpose: output element (r,c) = input element (c,r).
- FSM states: FILL, WAIT, DRAIN.
- FILL:
  - `in_ready`=1.
  - Each `in_valid`&&`in_ready` writes `in_row` into matrix row `row_idx`, then increments `row_idx` (2 bits).
  - On the accept with `row_idx`=3: `row_idx` wraps to 0, `lat_cnt` loads XF_LAT, and the FSM moves to WAIT.
- WAIT:
  - `in_ready`=0.
  - `lat_cnt` decrements each cycle.
  - When `lat_cnt`=0, the transform output is captured into the output buffer and the FSM moves to DRAIN.
- DRAIN:
  - `out_valid`=1; `out_row` = buffer row `row_idx`; `out_last`=(`row_idx`==3).
  - Each `out_valid`&&`out_ready` increments `row_idx`.
  - On the handshake with `row_idx`=3: `row_idx` wraps to 0, `frame_cnt` increments (wrapping modulo 2^CNT_W), and the FSM moves to FILL.
- Handshake rules:
  - `out_row` and `out_last` hold stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a handshake.
  - `in_ready` does not depend combinationally on `in_valid`.
- No overlap between frames: the next frame's rows are not accepted until the current frame is fully drained.
- Reset values (asynchronous, applied immediately):
  - State = FILL; `row_idx`=0; `lat_cnt`=0; matrix and output buffer = 0.
  - `in_ready`=1 (after release); `out_valid`=0; `out_last`=0; `out_row`=0; `busy`=0; `frame_cnt`=0.
- Reset asserted mid-frame in any state discards all partial rows and undrained output. After release, the block starts a fresh frame at row 0.

## Timing
- Input: one row per cycle at most, so four accepts take at minimum 4 cycles.
- Latency: 4th input accept at edge k → `out_valid` high after edge k+XF_LAT+1. With XF_LAT=1, the first output row is visible 2 cycles after the last input accept.
- Output: one row per cycle with `out_ready` held high.
- Minimum frame period: 4 + XF_LAT + 1 + 4 cycles (10 cycles at defaults).
- `in_ready` rises on the cycle after the final output handshake.
- Back-pressure in DRAIN stalls indefinitely without data loss. Upstream is simply held off (`in_ready`=0).
- `busy` and `frame_cnt` are registered and update on the same edge as the state change.

## Structure
- Shared package/header `mat4x4_pkg`:
  - State encodings FILL/WAIT/DRAIN (2 bits).
  - ROWS=4.
  - Row-slice helper macro/function for 4W-bit rows.
- One sub-module: `data_4x4_transform` (existing datapath), instantiated once.
  - `data` is driven from the matrix register; `data_out` feeds the output-buffer capture.
  - Its `clk`/`rstn` are shared with this block.
- Controller logic (FSM, counters, buffers) lives in this module; no further hierarchy.

## Test plan
- Basic transpose, W=8, XF_LAT=1, `out_ready`=1: rows 0x01010101, 0x02020202, 0x03030303, 0x04040404 on consecutive cycles → four rows of 0x04030201, with `out_last` on the 4th. First `out_valid` 2 cycles after the 4th accept; `frame_cnt`=1.
- Non-symmetric matrix: rows 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C → rows 0x0C080400, 0x0D090501, 0x0E0A0602, 0x0F0B0703.
- Back-pressure: `out_ready` low for 5 cycles mid-drain → `out_row`/`out_last` stable throughout, `in_ready`=0, no rows lost or duplicated.
- Bubbly input: `in_valid` toggling 1/0 → matrix fills only on handshakes, and the result is identical to the basic test. With `in_valid` held high during WAIT/DRAIN, no rows are accepted.
- Reset mid-operation: assert `rstn`=0 after 2 rows are accepted, then again during DRAIN → all outputs return to reset values immediately. The next 4 rows produce a correct frame, and `frame_cnt` restarts from 0.
- Counter wrap and latency sweep: CNT_W=2 with 5 frames → `frame_cnt` reads 1, 2, 3, 0, 1. XF_LAT=3 → first `out_valid` 4 cycles after the 4th accept.
